burst_axi_rd_engine: RTL and testbench
======================================

Name: burst_axi_rd_engine

Overview:
- Responder side of the burst request interface driven by the memcpy state machine.
- Accepts one burst command at a time: start pulse, 8-bit length and 64-bit address.
- Executes the command as a single AXI4 INCR read burst of 64-bit beats and forwards the beats to a downstream valid/ready sink.
- Reports busy while a command is in flight and pulses done on completion.

Parameters:
- ID_W, 4, width of the AXI ARID/RID fields.
- AR_ID, 0, constant ID driven on ARID; RID is expected to match.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- burst_start  in  1  one-cycle command strobe
- burst_len  in  8  beats in the burst; 0 means 256 beats
- burst_addr  in  64  byte address of the first beat; bits [2:0] are ignored
- burst_busy  out  1  command accepted and not yet completed
- burst_done  out  1  one-cycle completion pulse
- rd_err  out  1  sticky error flag for the current burst
- m_axi_araddr  out  64  AXI read address
- m_axi_arlen  out  8  AXI burst length (beats-1)
- m_axi_arsize  out  3  constant 3'b011 (8 bytes per beat)
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_arid  out  ID_W  constant AR_ID
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address ready
- m_axi_rdata  in  64  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat of the burst
- m_axi_rid  in  ID_W  read ID
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready
- dout_data  out  64  data to sink
- dout_last  out  1  final beat of the burst
- dout_valid  out  1  sink data valid
- dout_ready  in  1  sink ready

Behaviour:
- Reset values: all outputs 0, except the constant fields arsize, arburst and arid.
- States are one-hot: IDLE, ADDR, DATA, DONE.
- IDLE:
  - burst_start=1 captures araddr={burst_addr[63:3],3'b0}.
  - Captures arlen=burst_len-1 using 8-bit wrap, so len 0 gives arlen 255 (256 beats).
  - Loads beat_cnt=arlen, clears rd_err, moves to ADDR.
- ADDR:
  - m_axi_arvalid=1 is registered and stays high until the arvalid&arready handshake.
  - Address and length are held stable while arvalid is high.
  - On the handshake, moves to DATA.
- DATA:
  - Combinational pass-through: m_axi_rready=dout_ready, dout_valid=m_axi_rvalid, dout_data=m_axi_rdata.
  - dout_last=(beat_cnt==0).
  - Each rvalid&rready beat decrements beat_cnt.
  - rd_err is set if rresp!=0, RID!=AR_ID, or rlast!=(beat_cnt==0) on any beat.
  - The beat with beat_cnt==0 moves the FSM to DONE, whatever rlast reads.
- DONE:
  - burst_done=1 for exactly one cycle (registered), then IDLE.
  - rd_err holds until the next accepted burst_start.
- burst_busy=1 in ADDR, DATA and DONE; it rises the cycle after burst_start.
- burst_start while busy is ignored, with no queuing. The requester guarantees it only starts when busy=0.
- Latency:
  - start to arvalid: 1 cycle.
  - last beat to burst_done: 1 cycle.
  - done to ready for the next command: 1 cycle.
- Outside DATA, rready=0 and dout_valid=0.
- Reset mid-burst returns the FSM to IDLE immediately and drops arvalid and rready. The AXI slave is reset on the same rst_n.
- No 4KB split: the requester already limits bursts to 2KB-aligned windows.

Decomposition:
- Shared package holds:
  - AXI constants: SIZE_8B=3'b011, BURST_INCR=2'b01, RESP_OKAY=2'b00.
  - The state encoding localparams, shared with the write-side engine.
- No sub-module. Pass-through with no skid buffer; a skid buffer is a later option if timing requires one.

Test Plan:
- Nominal 4-beat burst: start, len=4, addr=0x1000, arready immediate. Expect arlen=3, araddr=0x1000, 4 beats on dout with last on beat 4, burst_done one cycle after beat 4, rd_err=0.
- Maximum burst: len=0, addr=0x2000. Expect arlen=255 and exactly 256 beats; dout_last only on beat 256.
- Backpressure: arready delayed 5 cycles, then dout_ready toggling 1/0 each cycle. Expect arvalid, araddr and arlen stable for those 5 cycles, no beats lost or duplicated, count 8 for len=8.
- Error flagging: rresp=2'b10 on beat 2 of 3, and separately rlast early on beat 1 of 2. Expect rd_err=1, burst_done still pulsed after the counted final beat, rd_err cleared on the next start.
- Unaligned address and ignored start: addr=0x1005 gives araddr=0x1000. A second burst_start while busy has no effect.
- Reset mid-burst: rst_n low during DATA. Expect busy, arvalid and rready at 0 at once; a fresh burst after reset completes normally.

Source files
------------

// File: rtl/burst_axi_rd_engine_pkg.sv
// Shared definitions for the burst read/write engines: AXI field constants
// and the one-hot engine state encoding.
package burst_axi_rd_engine_pkg;

    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // One-hot encodings, also used by the write-side engine
    localparam logic [3:0] ENC_IDLE = 4'b0001;
    localparam logic [3:0] ENC_ADDR = 4'b0010;
    localparam logic [3:0] ENC_DATA = 4'b0100;
    localparam logic [3:0] ENC_DONE = 4'b1000;

    typedef enum logic [3:0] {
        ST_IDLE = ENC_IDLE,
        ST_ADDR = ENC_ADDR,
        ST_DATA = ENC_DATA,
        ST_DONE = ENC_DONE
    } state_t;

endpackage

// File: rtl/burst_axi_rd_engine.sv
// Executes one burst command as a single AXI4 INCR read burst and streams
// the returned beats straight through to a valid/ready sink.
module burst_axi_rd_engine
    import burst_axi_rd_engine_pkg::*;
#(
    parameter int ID_W  = 4,
    parameter int AR_ID = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            burst_start,
    input  logic [7:0]      burst_len,
    input  logic [63:0]     burst_addr,
    output logic            burst_busy,
    output logic            burst_done,
    output logic            rd_err,
    output logic [63:0]     m_axi_araddr,
    output logic [7:0]      m_axi_arlen,
    output logic [2:0]      m_axi_arsize,
    output logic [1:0]      m_axi_arburst,
    output logic [ID_W-1:0] m_axi_arid,
    output logic            m_axi_arvalid,
    input  logic            m_axi_arready,
    input  logic [63:0]     m_axi_rdata,
    input  logic [1:0]      m_axi_rresp,
    input  logic            m_axi_rlast,
    input  logic [ID_W-1:0] m_axi_rid,
    input  logic            m_axi_rvalid,
    output logic            m_axi_rready,
    output logic [63:0]     dout_data,
    output logic            dout_last,
    output logic            dout_valid,
    input  logic            dout_ready
);

    localparam logic [ID_W-1:0] AR_ID_V = ID_W'(AR_ID);

    state_t      state;
    state_t      state_nxt;
    logic [63:0] araddr_q;
    logic [7:0]  arlen_q;
    logic [7:0]  beat_cnt;
    logic        rd_err_q;
    logic        in_data;
    logic        beat;
    logic        final_beat;
    logic        beat_bad;
    logic        unused_addr_lsbs;

    // Byte offset within the first beat has no meaning for 8-byte beats
    assign unused_addr_lsbs = ^burst_addr[2:0];

    assign in_data    = (state == ST_DATA);
    assign beat       = in_data & m_axi_rvalid & dout_ready;
    assign final_beat = (beat_cnt == 8'd0);
    assign beat_bad   = (m_axi_rresp != RESP_OKAY) | (m_axi_rid != AR_ID_V)
                      | (m_axi_rlast != final_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Completion follows our own beat count; rlast is only checked, never trusted
    always_comb begin
        state_nxt     = state;
        burst_busy    = 1'b1;
        burst_done    = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        dout_valid    = 1'b0;
        dout_data     = 64'd0;
        dout_last     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                burst_busy = 1'b0;
                if (burst_start) begin
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axi_rready = dout_ready;
                dout_valid   = m_axi_rvalid;
                dout_data    = m_axi_rdata;
                dout_last    = final_beat;
                if (beat && final_beat) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                burst_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: begin
                burst_busy = 1'b0;
                state_nxt  = ST_IDLE;
            end
        endcase
    end

    // Command capture; len 0 wraps to arlen 255 for a full 256-beat burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            araddr_q <= 64'd0;
            arlen_q  <= 8'd0;
            beat_cnt <= 8'd0;
            rd_err_q <= 1'b0;
        end else if ((state == ST_IDLE) && burst_start) begin
            araddr_q <= {burst_addr[63:3], 3'b000};
            arlen_q  <= burst_len - 8'd1;
            beat_cnt <= burst_len - 8'd1;
            rd_err_q <= 1'b0;
        end else if (beat) begin
            beat_cnt <= beat_cnt - 8'd1;
            if (beat_bad) begin
                rd_err_q <= 1'b1;
            end
        end
    end

    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = SIZE_8B;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arid    = AR_ID_V;
    assign rd_err        = rd_err_q;

endmodule

// File: tb/tb_burst_axi_rd_engine.sv
// Directed self-checking bench for burst_axi_rd_engine; the bench plays the
// AXI read slave and the downstream sink.
module tb_burst_axi_rd_engine;

    logic        clk;
    logic        rst_n;
    logic        burst_start;
    logic [7:0]  burst_len;
    logic [63:0] burst_addr;
    logic        burst_busy;
    logic        burst_done;
    logic        rd_err;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic [3:0]  m_axi_arid;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic [3:0]  m_axi_rid;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [63:0] dout_data;
    logic        dout_last;
    logic        dout_valid;
    logic        dout_ready;

    int n_checks = 0;
    int n_fail   = 0;

    burst_axi_rd_engine #(.ID_W(4), .AR_ID(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .burst_start(burst_start), .burst_len(burst_len), .burst_addr(burst_addr),
        .burst_busy(burst_busy), .burst_done(burst_done), .rd_err(rd_err),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arid(m_axi_arid), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rid(m_axi_rid), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .dout_data(dout_data),
        .dout_last(dout_last), .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle command strobe; returns one cycle after the accepting edge
    task automatic start_burst(input logic [7:0] len, input logic [63:0] addr);
        burst_start = 1'b1;
        burst_len   = len;
        burst_addr  = addr;
        tick();
        burst_start = 1'b0;
        burst_len   = 8'd0;
        burst_addr  = 64'd0;
    endtask

    // Holds arready low for 'delay' cycles, counting cycles where the address
    // phase was not held stable, then completes the handshake
    task automatic addr_phase(input int delay, input logic [63:0] exp_addr,
                              input logic [7:0] exp_len, output int unstable,
                              output logic arvalid_after);
        unstable = 0;
        for (int c = 0; c < delay; c++) begin
            if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== exp_addr ||
                m_axi_arlen !== exp_len)
                unstable++;
            tick();
        end
        if (m_axi_arvalid !== 1'b1) unstable++;
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        arvalid_after = m_axi_arvalid;
    endtask

    // Plays the slave and sink for n beats; beat index err_beat gets SLVERR
    // and beat index early_last gets rlast asserted besides the true last one
    task automatic serve_data(input int n, input int err_beat, input int early_last,
                              input bit toggle, output int got, output int last_cnt,
                              output int last_at, output int bad, output bit timeout,
                              output logic done1, output logic done2,
                              output logic busy2, output logic err_end,
                              output logic gated_bad);
        int   i = 0;
        int   cyc = 0;
        bit   rdy = 1'b1;
        bit   hs;
        logic [63:0] d;
        got = 0; last_cnt = 0; last_at = -1; bad = 0;
        while (i < n && cyc < 4000) begin
            d = 64'hA5A5_0000_0000_0000 + 64'(i) * 64'h0001_0001;
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = d;
            m_axi_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            m_axi_rlast  = (i == n - 1) || (i == early_last);
            m_axi_rid    = 4'd0;
            dout_ready   = toggle ? rdy : 1'b1;
            #1;
            if (dout_valid !== 1'b1 || dout_data !== d ||
                m_axi_rready !== dout_ready || burst_busy !== 1'b1)
                bad++;
            hs = (dout_valid === 1'b1) && (dout_ready === 1'b1);
            if (hs && dout_last === 1'b1) begin
                last_cnt++;
                last_at = i;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (hs) begin
                i++;
                got++;
            end
            rdy = ~rdy;
        end
        timeout    = (i < n);
        dout_ready = 1'b1;
        #1;
        done1     = burst_done;
        err_end   = rd_err;
        gated_bad = m_axi_rready | dout_valid | ~burst_busy;
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
        tick();
        done2 = burst_done;
        busy2 = burst_busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        burst_start = 0; burst_len = 0; burst_addr = 0;
        m_axi_arready = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0;
        m_axi_rid = 0; m_axi_rvalid = 0; dout_ready = 0;
        repeat (3) tick();
        n_checks++;
        if ({burst_busy, burst_done, rd_err, m_axi_arvalid, m_axi_rready,
             dout_valid, dout_last} !== 7'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
                     {burst_busy, burst_done, rd_err, m_axi_arvalid, m_axi_rready,
                      dout_valid, dout_last});
        end
        n_checks++;
        if (m_axi_araddr !== 64'd0 || m_axi_arlen !== 8'd0 || dout_data !== 64'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: araddr %h arlen %h dout %h expected zeros",
                     m_axi_araddr, m_axi_arlen, dout_data);
        end
        n_checks++;
        if (m_axi_arsize !== 3'b011 || m_axi_arburst !== 2'b01 || m_axi_arid !== 4'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_const: size %b burst %b id %h expected 011 01 0",
                     m_axi_arsize, m_axi_arburst, m_axi_arid);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // Shared check block for a completed burst, written out per test
    task automatic test_nominal();
        int got, lc, la, bad, unst;
        bit to;
        logic d1, d2, b2, e, g, av;
        start_burst(8'd4, 64'h1000);
        n_checks++;
        if (burst_busy !== 1'b1 || m_axi_arvalid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL nom_start: busy %b arvalid %b expected 1 1",
                     burst_busy, m_axi_arvalid);
        end
        n_checks++;
        if (m_axi_araddr !== 64'h1000 || m_axi_arlen !== 8'd3) begin
            n_fail++;
            $display("[TB] FAIL nom_ar: araddr %h arlen %0d expected 1000 3",
                     m_axi_araddr, m_axi_arlen);
        end
        addr_phase(0, 64'h1000, 8'd3, unst, av);
        n_checks++;
        if (av !== 1'b0 || unst != 0) begin
            n_fail++;
            $display("[TB] FAIL nom_handshake: arvalid after %b unstable %0d expected 0 0",
                     av, unst);
        end
        serve_data(4, -1, -1, 1'b0, got, lc, la, bad, to, d1, d2, b2, e, g);
        n_checks++;
        if (to || got != 4 || bad != 0) begin
            n_fail++;
            $display("[TB] FAIL nom_beats: got %0d bad %0d timeout %0d expected 4 0 0",
                     got, bad, to);
        end
        n_checks++;
        if (lc != 1 || la != 3) begin
            n_fail++;
            $display("[TB] FAIL nom_last: count %0d at %0d expected 1 at 3", lc, la);
        end
        n_checks++;
        if (d1 !== 1'b1 || d2 !== 1'b0 || b2 !== 1'b0 || e !== 1'b0 || g !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL nom_done: done %b%b busy %b err %b gated %b expected 10 0 0 0",
                     d1, d2, b2, e, g);
        end
    endtask

    task automatic test_max_burst();
        int got, lc, la, bad, unst;
        bit to;
        logic d1, d2, b2, e, g, av;
        start_burst(8'd0, 64'h2000);
        n_checks++;
        if (m_axi_arlen !== 8'd255 || m_axi_araddr !== 64'h2000) begin
            n_fail++;
            $display("[TB] FAIL max_ar: arlen %0d araddr %h expected 255 2000",
                     m_axi_arlen, m_axi_araddr);
        end
        addr_phase(0, 64'h2000, 8'd255, unst, av);
        serve_data(256, -1, -1, 1'b0, got, lc, la, bad, to, d1, d2, b2, e, g);
        n_checks++;
        if (to || got != 256 || bad != 0 || lc != 1 || la != 255) begin
            n_fail++;
            $display("[TB] FAIL max_beats: got %0d bad %0d last %0d@%0d expected 256 0 1@255",
                     got, bad, lc, la);
        end
        n_checks++;
        if (d1 !== 1'b1 || d2 !== 1'b0 || e !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL max_done: done %b%b err %b expected 10 0", d1, d2, e);
        end
    endtask

    task automatic test_backpressure();
        int got, lc, la, bad, unst;
        bit to;
        logic d1, d2, b2, e, g, av;
        start_burst(8'd8, 64'h4_0000_8040);
        addr_phase(5, 64'h4_0000_8040, 8'd7, unst, av);
        n_checks++;
        if (unst != 0 || av !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_addr_stable: unstable %0d arvalid after %b expected 0 0",
                     unst, av);
        end
        serve_data(8, -1, -1, 1'b1, got, lc, la, bad, to, d1, d2, b2, e, g);
        n_checks++;
        if (to || got != 8 || bad != 0 || lc != 1 || la != 7) begin
            n_fail++;
            $display("[TB] FAIL bp_beats: got %0d bad %0d last %0d@%0d expected 8 0 1@7",
                     got, bad, lc, la);
        end
        n_checks++;
        if (d1 !== 1'b1 || d2 !== 1'b0 || b2 !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_done: done %b%b busy %b expected 10 0", d1, d2, b2);
        end
    endtask

    task automatic test_errors();
        int got, lc, la, bad, unst;
        bit to;
        logic d1, d2, b2, e, g, av;
        start_burst(8'd3, 64'h3000);
        addr_phase(0, 64'h3000, 8'd2, unst, av);
        serve_data(3, 1, -1, 1'b0, got, lc, la, bad, to, d1, d2, b2, e, g);
        n_checks++;
        if (to || got != 3 || e !== 1'b1 || d1 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL err_resp: got %0d err %b done %b expected 3 1 1", got, e, d1);
        end
        n_checks++;
        if (rd_err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL err_sticky: rd_err %b expected 1", rd_err);
        end
        start_burst(8'd2, 64'h3100);
        n_checks++;
        if (rd_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL err_clear: rd_err %b expected 0", rd_err);
        end
        addr_phase(0, 64'h3100, 8'd1, unst, av);
        serve_data(2, -1, 0, 1'b0, got, lc, la, bad, to, d1, d2, b2, e, g);
        n_checks++;
        if (to || got != 2 || e !== 1'b1 || d1 !== 1'b1 || d2 !== 1'b0 || la != 1) begin
            n_fail++;
            $display("[TB] FAIL err_early_last: got %0d err %b done %b%b last@%0d expected 2 1 10 1",
                     got, e, d1, d2, la);
        end
    endtask

    task automatic test_unaligned_ignore();
        int got, lc, la, bad, unst;
        bit to;
        logic d1, d2, b2, e, g, av;
        start_burst(8'd2, 64'h1005);
        n_checks++;
        if (rd_err !== 1'b0 || m_axi_araddr !== 64'h1000) begin
            n_fail++;
            $display("[TB] FAIL unal_addr: araddr %h err %b expected 1000 0",
                     m_axi_araddr, rd_err);
        end
        start_burst(8'd9, 64'h5000);
        n_checks++;
        if (m_axi_araddr !== 64'h1000 || m_axi_arlen !== 8'd1 || m_axi_arvalid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ignore_start: araddr %h arlen %0d arvalid %b expected 1000 1 1",
                     m_axi_araddr, m_axi_arlen, m_axi_arvalid);
        end
        addr_phase(1, 64'h1000, 8'd1, unst, av);
        serve_data(2, -1, -1, 1'b0, got, lc, la, bad, to, d1, d2, b2, e, g);
        n_checks++;
        if (to || got != 2 || la != 1 || d1 !== 1'b1 || d2 !== 1'b0 || unst != 0) begin
            n_fail++;
            $display("[TB] FAIL ignore_burst: got %0d last@%0d done %b%b unstable %0d expected 2 1 10 0",
                     got, la, d1, d2, unst);
        end
    endtask

    task automatic test_reset_mid_burst();
        int got, lc, la, bad, unst;
        bit to;
        logic d1, d2, b2, e, g, av;
        start_burst(8'd6, 64'h6000);
        addr_phase(0, 64'h6000, 8'd5, unst, av);
        m_axi_rvalid = 1'b1;
        m_axi_rlast  = 1'b0;
        dout_ready   = 1'b1;
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (burst_busy !== 1'b0 || m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 ||
            dout_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid: busy %b arvalid %b rready %b dvalid %b expected 0 0 0 0",
                     burst_busy, m_axi_arvalid, m_axi_rready, dout_valid);
        end
        m_axi_rvalid = 1'b0;
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        start_burst(8'd2, 64'h7000);
        addr_phase(0, 64'h7000, 8'd1, unst, av);
        serve_data(2, -1, -1, 1'b0, got, lc, la, bad, to, d1, d2, b2, e, g);
        n_checks++;
        if (to || got != 2 || bad != 0 || la != 1 || d1 !== 1'b1 || e !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_fresh: got %0d bad %0d last@%0d done %b err %b expected 2 0 1 1 0",
                     got, bad, la, d1, e);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_max_burst();
        test_backpressure();
        test_errors();
        test_unaligned_ignore();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
